// File: rtl/subword_mem_responder.sv
// -----------------------------------------------------------------------------
// subword_mem_responder
//
// Purpose:
//   Data-memory-side responder for the Harvard CPU. The CPU issues byte,
//   halfword and word loads/stores; the data RAM only understands whole,
//   word-aligned words. This block translates between the two:
//     - sub-word loads  : word read, then lane extraction + sign/zero extend
//     - sub-word stores : read-modify-write (read word, merge lane, write word)
//     - word loads      : single word read
//     - word stores     : single word write
//   The CPU is stalled while a transaction is in flight.
//
//   Byte order is little-endian: byte lane k = addr[1:0] lives in bits
//   [8k+7:8k]; the halfword lane is chosen by addr[1] (0 = [15:0],
//   1 = [31:16]).
//
// Parameters:
//   ADDR_WIDTH      byte-address width of the CPU and RAM buses (>= 3)
//   TIMEOUT_CYCLES  max consecutive mem_waitrequest cycles in one bus phase
//                   before the phase is abandoned with cpu_err=1. 0 disables
//                   the timeout. The counter is 8 bits, so the useful range
//                   is 0..255.
//
// Optional feature (compile-time macro SUBWORD_MISALIGN_TRAP_EN):
//   Defined   : a halfword with addr[0]=1 or a word with addr[1:0]!=00 is
//               trapped without touching the RAM: DONE follows the accepting
//               cycle directly, with cpu_err=1 and cpu_rdata=0.
//   Undefined : no alignment check; word accesses ignore addr[1:0] and
//               halfword accesses ignore addr[0].
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous, active-high reset
//   cpu_req          request valid (level), sampled only in IDLE
//   cpu_we           1 = store, 0 = load
//   cpu_size         00 = byte, 01 = half, 10/11 = word
//   cpu_unsigned     1 = zero-extend loads, 0 = sign-extend
//   cpu_addr         byte address
//   cpu_wdata        store data, right-justified
//   cpu_stall        hold the CPU pipeline (combinational)
//   cpu_done         one-cycle completion pulse
//   cpu_err          error flag, valid with cpu_done
//   cpu_rdata        load result, valid with cpu_done, held until the next
//                    load completion (stores leave it untouched)
//   mem_read         RAM read strobe
//   mem_write        RAM write strobe
//   mem_addr         word-aligned RAM address (bits [1:0] = 00)
//   mem_writedata    RAM write data
//   mem_readdata     RAM read data, valid when mem_read=1 and waitrequest=0
//   mem_waitrequest  RAM not ready; strobes/address are held while high
// -----------------------------------------------------------------------------
module subword_mem_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_unsigned,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_stall,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic [31:0]           cpu_rdata,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_writedata,
    input  logic [31:0]           mem_readdata,
    input  logic                  mem_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam bit         TO_EN    = (TIMEOUT_CYCLES != 0);

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            lane_q, lane_d;
    // Only the low halfword of store data is ever merged into a read word;
    // full-word store data goes straight into mem_writedata on acceptance.
    logic [15:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_writedata_q, mem_writedata_d;
    logic [31:0]           cpu_rdata_q, cpu_rdata_d;
    logic                  cpu_err_q, cpu_err_d;
    logic [7:0]            to_cnt_q, to_cnt_d;

    logic [7:0]            to_cnt_inc;
    logic                  to_hit;

    // -------------------------------------------------------------------------
    // Lane helpers
    // -------------------------------------------------------------------------

    // Pick the addressed lane out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_lane(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   load_lane = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   load_lane = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_lane = word;
        endcase
    endfunction

    // Replace the addressed lane of a RAM word with right-justified store
    // data, leaving the other lanes untouched.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic [15:0] wd
    );
        logic [31:0] m;
        m = word;
        case (size)
            2'b00: m[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) m[31:16] = wd;
                else         m[15:0]  = wd;
            end
            // Word stores never take the read-modify-write path.
            default: m = word;
        endcase
        merge_lane = m;
    endfunction

`ifdef SUBWORD_MISALIGN_TRAP_EN
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lo[0];
            default: misaligned = (lo != 2'b00);
        endcase
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Wait-state timeout: the counter counts waitrequest cycles within the
    // current bus phase; the phase is abandoned on the cycle the count
    // reaches the limit, so the strobe is high for exactly TO_LIMIT cycles.
    // -------------------------------------------------------------------------
    assign to_cnt_inc = to_cnt_q + 8'd1;
    assign to_hit     = TO_EN && (to_cnt_inc == TO_LIMIT);

    // -------------------------------------------------------------------------
    // Next-state / datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        we_d            = we_q;
        size_d          = size_q;
        uns_d           = uns_q;
        lane_d          = lane_q;
        wdata_d         = wdata_q;
        mem_addr_d      = mem_addr_q;
        mem_writedata_d = mem_writedata_q;
        cpu_rdata_d     = cpu_rdata_q;
        cpu_err_d       = cpu_err_q;
        to_cnt_d        = to_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d       = cpu_we;
                    size_d     = cpu_size;
                    uns_d      = cpu_unsigned;
                    lane_d     = cpu_addr[1:0];
                    wdata_d    = cpu_wdata[15:0];
                    mem_addr_d = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                    cpu_err_d  = 1'b0;
                    to_cnt_d   = 8'd0;
`ifdef SUBWORD_MISALIGN_TRAP_EN
                    if (misaligned(cpu_size, cpu_addr[1:0])) begin
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = 32'h0;
                        state_d     = S_DONE;
                    end else
`endif
                    if (cpu_we && cpu_size[1]) begin
                        mem_writedata_d = cpu_wdata;
                        state_d         = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                if (!mem_waitrequest) begin
                    if (!we_q) begin
                        cpu_rdata_d = load_lane(mem_readdata, size_q, lane_q, uns_q);
                        state_d     = S_DONE;
                    end else begin
                        mem_writedata_d = merge_lane(mem_readdata, size_q, lane_q, wdata_q);
                        to_cnt_d        = 8'd0;
                        state_d         = S_WRITE;
                    end
                end else begin
                    to_cnt_d = to_cnt_inc;
                    if (to_hit) begin
                        cpu_err_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end

            S_WRITE: begin
                if (!mem_waitrequest) begin
                    state_d = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_inc;
                    if (to_hit) begin
                        cpu_err_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // cpu_req is deliberately ignored here: the CPU sees
                // cpu_stall low this cycle and presents its next request
                // after the edge.
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            we_q            <= 1'b0;
            size_q          <= 2'b00;
            uns_q           <= 1'b0;
            lane_q          <= 2'b00;
            wdata_q         <= 16'h0;
            mem_addr_q      <= '0;
            mem_writedata_q <= 32'h0;
            cpu_rdata_q     <= 32'h0;
            cpu_err_q       <= 1'b0;
            to_cnt_q        <= 8'd0;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            lane_q          <= lane_d;
            wdata_q         <= wdata_d;
            mem_addr_q      <= mem_addr_d;
            mem_writedata_q <= mem_writedata_d;
            cpu_rdata_q     <= cpu_rdata_d;
            cpu_err_q       <= cpu_err_d;
            to_cnt_q        <= to_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Strobes and cpu_done decode straight from the state register,
    // so they can never overlap and drop immediately on an asynchronous reset.
    // -------------------------------------------------------------------------
    assign mem_read      = (state_q == S_READ);
    assign mem_write     = (state_q == S_WRITE);
    assign mem_addr      = mem_addr_q;
    assign mem_writedata = mem_writedata_q;

    assign cpu_done  = (state_q == S_DONE);
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_stall = ((state_q == S_IDLE) && cpu_req)
                     || (state_q == S_READ)
                     || (state_q == S_WRITE);

endmodule
